// File: rtl/mor1kx_dpram_fifo.sv
// mor1kx_dpram_fifo: single-clock first-word-fall-through FIFO built on a
// simple dual-port RAM with one-cycle read latency. A one-entry output stage
// holds the head when the consumer stalls, so push and pop both sustain one
// per cycle. Total capacity is 2**ADDR_WIDTH RAM entries plus one held entry.
// Optional feature: define MOR1KX_DPRAM_FIFO_LEVEL_EN to add the level_o
// occupancy port.

// Simple single-clock dual-port RAM with registered read data.
// Contents are never cleared; dout_o only changes on a read.
module mor1kx_simple_dpram_sclk #(
  parameter int ADDR_WIDTH    = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int ENABLE_BYPASS = 0
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic                  we_i,
  input  logic [DATA_WIDTH-1:0] din_i,
  output logic [DATA_WIDTH-1:0] dout_o
);

  logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];
  logic [DATA_WIDTH-1:0] dout_q;

  // Storage write port.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[waddr_i] <= din_i;
    end
  end

  // Registered read port; optional write-to-read bypass on an address match.
  always_ff @(posedge clk) begin
    if (re_i) begin
      if ((ENABLE_BYPASS != 0) && we_i && (waddr_i == raddr_i)) begin
        dout_q <= din_i;
      end else begin
        dout_q <= mem[raddr_i];
      end
    end
  end

  assign dout_o = dout_q;

endmodule

module mor1kx_dpram_fifo #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  wr_valid_i,
  output logic                  wr_ready_o,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_valid_o,
  input  logic                  rd_ready_i
`ifdef MOR1KX_DPRAM_FIFO_LEVEL_EN
  ,
  output logic [ADDR_WIDTH+1:0] level_o
`endif
);

  localparam logic [ADDR_WIDTH:0]   CNT_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   ram_cnt_q, ram_cnt_d;
  logic                  fetch_pend_q, fetch_pend_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_reg_q, out_reg_d;

  logic                  wr_accept_s;
  logic                  pop_s;
  logic                  issue_s;
  logic [DATA_WIDTH-1:0] ram_dout_s;

  // wr_ready_o depends only on RAM occupancy, never on the output stage.
  assign wr_ready_o  = (ram_cnt_q != CNT_FULL) & ~flush_i;
  assign wr_accept_s = wr_valid_i & wr_ready_o;
  assign rd_valid_o  = fetch_pend_q | out_valid_q;
  assign pop_s       = rd_valid_o & rd_ready_i;
  // Fetch the next word whenever the head slot is free or being vacated.
  assign issue_s     = (ram_cnt_q != {(ADDR_WIDTH+1){1'b0}}) & (~rd_valid_o | pop_s) & ~flush_i;
  // Word arriving from RAM this cycle goes straight out; else the held copy.
  assign rd_data_o   = fetch_pend_q ? ram_dout_s : out_reg_q;

`ifdef MOR1KX_DPRAM_FIFO_LEVEL_EN
  assign level_o = {1'b0, ram_cnt_q} + {{(ADDR_WIDTH+1){1'b0}}, rd_valid_o};
`endif

  mor1kx_simple_dpram_sclk #(
    .ADDR_WIDTH   (ADDR_WIDTH),
    .DATA_WIDTH   (DATA_WIDTH),
    .ENABLE_BYPASS(0)
  ) u_ram (
    .clk    (clk),
    .raddr_i(rd_ptr_q),
    .re_i   (issue_s),
    .waddr_i(wr_ptr_q),
    .we_i   (wr_accept_s),
    .din_i  (wr_data_i),
    .dout_o (ram_dout_s)
  );

  // Next-state for pointers, RAM count and output stage; flush wins over all.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    ram_cnt_d    = ram_cnt_q;
    fetch_pend_d = 1'b0;
    out_valid_d  = out_valid_q;
    out_reg_d    = out_reg_q;
    if (flush_i) begin
      wr_ptr_d     = {ADDR_WIDTH{1'b0}};
      rd_ptr_d     = {ADDR_WIDTH{1'b0}};
      ram_cnt_d    = {(ADDR_WIDTH+1){1'b0}};
      fetch_pend_d = 1'b0;
      out_valid_d  = 1'b0;
      out_reg_d    = {DATA_WIDTH{1'b0}};
    end else begin
      if (wr_accept_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (issue_s) begin
        rd_ptr_d     = rd_ptr_q + PTR_ONE;
        fetch_pend_d = 1'b1;
      end else begin
        rd_ptr_d     = rd_ptr_q;
        fetch_pend_d = 1'b0;
      end
      case ({wr_accept_s, issue_s})
        2'b10:   ram_cnt_d = ram_cnt_q + CNT_ONE;
        2'b01:   ram_cnt_d = ram_cnt_q - CNT_ONE;
        default: ram_cnt_d = ram_cnt_q;
      endcase
      // A fetched word not consumed on arrival is parked in the output stage.
      if (fetch_pend_q && !pop_s) begin
        out_reg_d   = ram_dout_s;
        out_valid_d = 1'b1;
      end else if (out_valid_q && pop_s) begin
        out_valid_d = 1'b0;
      end else begin
        out_valid_d = out_valid_q;
      end
    end
  end

  // State registers; asynchronous reset discards any in-flight fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= {ADDR_WIDTH{1'b0}};
      rd_ptr_q     <= {ADDR_WIDTH{1'b0}};
      ram_cnt_q    <= {(ADDR_WIDTH+1){1'b0}};
      fetch_pend_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_reg_q    <= {DATA_WIDTH{1'b0}};
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      ram_cnt_q    <= ram_cnt_d;
      fetch_pend_q <= fetch_pend_d;
      out_valid_q  <= out_valid_d;
      out_reg_q    <= out_reg_d;
    end
  end

endmodule

// File: tb/tb_mor1kx_dpram_fifo.sv
// Directed + scoreboard testbench for mor1kx_dpram_fifo (ADDR_WIDTH=4).
module tb_mor1kx_dpram_fifo;

  localparam int AW = 4;
  localparam int DW = 32;

  logic          clk;
  logic          rst_n;
  logic          flush_i;
  logic [DW-1:0] wr_data_i;
  logic          wr_valid_i;
  logic          wr_ready_o;
  logic [DW-1:0] rd_data_o;
  logic          rd_valid_o;
  logic          rd_ready_i;
`ifdef MOR1KX_DPRAM_FIFO_LEVEL_EN
  logic [AW+1:0] level_o;
`endif

  mor1kx_dpram_fifo #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush_i   (flush_i),
    .wr_data_i (wr_data_i),
    .wr_valid_i(wr_valid_i),
    .wr_ready_o(wr_ready_o),
    .rd_data_o (rd_data_o),
    .rd_valid_o(rd_valid_o),
    .rd_ready_i(rd_ready_i)
`ifdef MOR1KX_DPRAM_FIFO_LEVEL_EN
    ,
    .level_o   (level_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  logic [DW-1:0] sb_q[$];
  logic          last_acc;
  logic          last_pop;
  logic          s_wr_ready;
  logic          s_rd_valid;
  logic [DW-1:0] s_rd_data;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: inputs already driven; sample at negedge, update the
  // scoreboard, then advance to just after the next posedge.
  task automatic cycle();
    logic [DW-1:0] exp_d;
    @(negedge clk);
    s_wr_ready = wr_ready_o;
    s_rd_valid = rd_valid_o;
    s_rd_data  = rd_data_o;
    last_acc   = wr_valid_i && wr_ready_o;
    last_pop   = rd_valid_o && rd_ready_i && !flush_i;
`ifdef MOR1KX_DPRAM_FIFO_LEVEL_EN
    check("level", {58'd0, level_o}, 64'(sb_q.size()));
`endif
    if (last_pop) begin
      check("sb_nonempty", {63'd0, sb_q.size() != 0}, 64'd1);
      if (sb_q.size() != 0) begin
        exp_d = sb_q.pop_front();
        check("pop_data", {32'd0, rd_data_o}, {32'd0, exp_d});
      end
    end
    if (last_acc) sb_q.push_back(wr_data_i);
    if (flush_i) sb_q.delete();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int nacc;
    int popped;
    int first_c;
    int last_c;
    int nxt;
    rst_n      = 1'b0;
    flush_i    = 1'b0;
    wr_data_i  = 32'd0;
    wr_valid_i = 1'b0;
    rd_ready_i = 1'b0;
    #12;
    check("reset_rd_valid", {63'd0, rd_valid_o}, 64'd0);
    check("reset_wr_ready", {63'd0, wr_ready_o}, 64'd1);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Latency: push 0xA5 into empty FIFO, visible two cycles later.
    wr_valid_i = 1'b1;
    wr_data_i  = 32'hA5;
    cycle();
    wr_valid_i = 1'b0;
    @(negedge clk);
    check("lat_t1_valid", {63'd0, rd_valid_o}, 64'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("lat_t2_valid", {63'd0, rd_valid_o}, 64'd1);
    check("lat_t2_data", {32'd0, rd_data_o}, 64'hA5);
    @(posedge clk);
    #1;
    rd_ready_i = 1'b1;
    cycle();
    rd_ready_i = 1'b0;
    check("lat_popped", {63'd0, last_pop}, 64'd1);

    // Fill: 18 offers with no consumer, 17 fit.
    nacc = 0;
    for (int i = 0; i < 18; i++) begin
      wr_valid_i = 1'b1;
      wr_data_i  = 32'(i);
      cycle();
      if (last_acc) nacc++;
    end
    wr_valid_i = 1'b0;
    check("fill_accepts", 64'(nacc), 64'd17);
    @(negedge clk);
    check("fill_wr_ready", {63'd0, wr_ready_o}, 64'd0);
    check("fill_head", {32'd0, rd_data_o}, 64'd0);
`ifdef MOR1KX_DPRAM_FIFO_LEVEL_EN
    check("fill_level", {58'd0, level_o}, 64'd17);
`endif
    @(posedge clk);
    #1;
    rd_ready_i = 1'b1;
    cycle();
    rd_ready_i = 1'b0;
    @(negedge clk);
    check("fill_pop_wr_ready", {63'd0, wr_ready_o}, 64'd1);
    @(posedge clk);
    #1;
    rd_ready_i = 1'b1;
    for (int c = 0; c < 40 && sb_q.size() != 0; c++) cycle();
    rd_ready_i = 1'b0;
    check("fill_drained", 64'(sb_q.size()), 64'd0);

    // Streaming: 100 values, one pop per cycle once flowing.
    rd_ready_i = 1'b1;
    nxt = 0; popped = 0; first_c = -1; last_c = -1;
    for (int c = 0; c < 200 && popped < 100; c++) begin
      wr_valid_i = (nxt < 100);
      wr_data_i  = 32'(nxt);
      cycle();
      if (last_acc) nxt++;
      if (last_pop) begin
        if (first_c < 0) first_c = c;
        last_c = c;
        popped++;
      end
    end
    wr_valid_i = 1'b0;
    rd_ready_i = 1'b0;
    check("stream_count", 64'(popped), 64'd100);
    check("stream_no_gaps", 64'(last_c - first_c), 64'd99);

    // Reset mid-stream with 5 entries held.
    for (int i = 0; i < 5; i++) begin
      wr_valid_i = 1'b1;
      wr_data_i  = 32'(100 + i);
      cycle();
    end
    wr_valid_i = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_rd_valid", {63'd0, rd_valid_o}, 64'd0);
    check("rst_mid_wr_ready", {63'd0, wr_ready_o}, 64'd1);
`ifdef MOR1KX_DPRAM_FIFO_LEVEL_EN
    check("rst_mid_level", {58'd0, level_o}, 64'd0);
`endif
    sb_q.delete();
    #5 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Flush with 8 entries held and a write offered in the same cycle.
    nacc = 0;
    for (int c = 0; c < 20 && nacc < 8; c++) begin
      wr_valid_i = 1'b1;
      wr_data_i  = 32'(200 + c);
      cycle();
      if (last_acc) nacc++;
    end
    wr_valid_i = 1'b0;
    cycle();
    cycle();
    flush_i    = 1'b1;
    wr_valid_i = 1'b1;
    wr_data_i  = 32'hDEAD;
    cycle();
    check("flush_wr_ready", {63'd0, s_wr_ready}, 64'd0);
    flush_i    = 1'b0;
    wr_valid_i = 1'b0;
    @(negedge clk);
    check("flush_rd_valid", {63'd0, rd_valid_o}, 64'd0);
`ifdef MOR1KX_DPRAM_FIFO_LEVEL_EN
    check("flush_level", {58'd0, level_o}, 64'd0);
`endif
    @(posedge clk);
    #1;
    wr_valid_i = 1'b1;
    wr_data_i  = 32'h3C;
    cycle();
    wr_valid_i = 1'b0;
    cycle();
    rd_ready_i = 1'b1;
    cycle();
    rd_ready_i = 1'b0;
    check("flush_readback_valid", {63'd0, s_rd_valid}, 64'd1);
    check("flush_readback_data", {32'd0, s_rd_data}, 64'h3C);
    cycle();
    check("flush_then_empty", {63'd0, s_rd_valid}, 64'd0);

    // Random backpressure against the scoreboard.
    for (int c = 0; c < 3000; c++) begin
      wr_valid_i = 1'($urandom_range(0, 1));
      wr_data_i  = $urandom;
      rd_ready_i = 1'($urandom_range(0, 1));
      cycle();
    end
    wr_valid_i = 1'b0;
    rd_ready_i = 1'b1;
    for (int c = 0; c < 40 && sb_q.size() != 0; c++) cycle();
    check("rand_drained", 64'(sb_q.size()), 64'd0);
    cycle();
    check("rand_empty_valid", {63'd0, s_rd_valid}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
